// File: rtl/iiitb_lfsr_checker.sv
// Self-synchronising checker for a 4-bit LFSR stream (b[n] = b[n-3] ^ b[n-4]).
// Hunts for LOCK_CNT consecutive predicted matches, then free-runs and counts errors.
module iiitb_lfsr_checker #(
    parameter int unsigned LOCK_CNT    = 8,
    parameter int unsigned LOSS_THRESH = 4,
    parameter int unsigned ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_bit,
    input  logic                 clr,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 zero_det,
    output logic [1:0]           state
);

    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned MISS_W  = $clog2(LOSS_THRESH + 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_THRESH - 1);
    localparam logic [2:0]         FILL_FULL  = 3'd4;
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        LOCKED = 2'b01
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [3:0]             r_h, w_h_nxt;
    logic [2:0]             r_fill, w_fill_nxt;
    logic [MATCH_W-1:0]     r_match_cnt, w_match_cnt_nxt;
    logic [MISS_W-1:0]      r_miss_cnt, w_miss_cnt_nxt;
    logic                   r_locked, w_locked_nxt;
    logic                   r_err_pulse, w_err_pulse_nxt;
    logic [ERR_CNT_W-1:0]   r_err_cnt, w_err_cnt_nxt;
    logic                   r_zero_det, w_zero_det_nxt;
    logic                   w_pred;

    assign w_pred = r_h[3] ^ r_h[2];

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= HUNT;
            r_h         <= 4'd0;
            r_fill      <= 3'd0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
            r_zero_det  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_h         <= w_h_nxt;
            r_fill      <= w_fill_nxt;
            r_match_cnt <= w_match_cnt_nxt;
            r_miss_cnt  <= w_miss_cnt_nxt;
            r_locked    <= w_locked_nxt;
            r_err_pulse <= w_err_pulse_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
            r_zero_det  <= w_zero_det_nxt;
        end
    end

    // Next-state and output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_h_nxt         = r_h;
        w_fill_nxt      = r_fill;
        w_match_cnt_nxt = r_match_cnt;
        w_miss_cnt_nxt  = r_miss_cnt;
        w_locked_nxt    = r_locked;
        w_err_pulse_nxt = 1'b0;
        w_err_cnt_nxt   = r_err_cnt;
        w_zero_det_nxt  = r_zero_det;

        if (in_valid) begin
            case (r_state)
                HUNT: begin
                    w_h_nxt = {r_h[2:0], in_bit};
                    if (r_fill != FILL_FULL) begin
                        w_fill_nxt = r_fill + 3'd1;
                    end else if (r_h == 4'd0 && !in_bit) begin
                        // All-zero lockup state would "match" forever; never lock on it
                        w_match_cnt_nxt = '0;
                        w_zero_det_nxt  = 1'b1;
                    end else begin
                        w_zero_det_nxt = 1'b0;
                        if (in_bit == w_pred) begin
                            if (r_match_cnt == MATCH_LAST) begin
                                w_state_nxt     = LOCKED;
                                w_locked_nxt    = 1'b1;
                                w_match_cnt_nxt = '0;
                                w_miss_cnt_nxt  = '0;
                            end else begin
                                w_match_cnt_nxt = r_match_cnt + MATCH_W'(1);
                            end
                        end else begin
                            w_match_cnt_nxt = '0;
                        end
                    end
                end
                LOCKED: begin
                    // Free-run on the prediction so a corrupt bit cannot propagate
                    w_h_nxt = {r_h[2:0], w_pred};
                    if (in_bit != w_pred) begin
                        w_err_pulse_nxt = 1'b1;
                        if (r_err_cnt != ERR_MAX) begin
                            w_err_cnt_nxt = r_err_cnt + ERR_CNT_W'(1);
                        end
                        if (r_miss_cnt == MISS_LAST) begin
                            w_state_nxt     = HUNT;
                            w_locked_nxt    = 1'b0;
                            w_fill_nxt      = 3'd0;
                            w_match_cnt_nxt = '0;
                            w_miss_cnt_nxt  = '0;
                        end else begin
                            w_miss_cnt_nxt = r_miss_cnt + MISS_W'(1);
                        end
                    end else begin
                        w_miss_cnt_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt  = HUNT;
                    w_locked_nxt = 1'b0;
                end
            endcase
        end

        if (clr) begin
            w_err_cnt_nxt = '0;
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_cnt   = r_err_cnt;
    assign zero_det  = r_zero_det;
    assign state     = r_state;

endmodule

// File: tb/tb_iiitb_lfsr_checker.sv
// Randomised self-checking bench for iiitb_lfsr_checker against a queue-based
// behavioural model; a second instance with a 4-bit error counter covers saturation.
module tb_iiitb_lfsr_checker;

    localparam int LOCK = 8;
    localparam int LOSS = 4;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_bit, clr;
    logic        locked, err_pulse, zero_det;
    logic [15:0] err_cnt;
    logic [1:0]  state;
    logic        locked4, err_pulse4, zero_det4;
    logic [3:0]  err_cnt4;
    logic [1:0]  state4;

    int checks = 0;
    int errors = 0;

    logic [0:14] pat;
    int          gen_idx;

    // Behavioural model: received/predicted bit history as a queue, oldest first
    int hist[$];
    int m_lock, m_matches, m_misses, m_pulse, m_zero, m_err, m_err4;

    always #5 clk = ~clk;

    iiitb_lfsr_checker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clr(clr),
        .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt),
        .zero_det(zero_det), .state(state)
    );

    iiitb_lfsr_checker #(.ERR_CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clr(clr),
        .locked(locked4), .err_pulse(err_pulse4), .err_cnt(err_cnt4),
        .zero_det(zero_det4), .state(state4)
    );

    function automatic logic [29:0] obs_vec();
        return {state, locked, err_pulse, zero_det,
                state4, locked4, err_pulse4, zero_det4, err_cnt, err_cnt4};
    endfunction

    function automatic logic [29:0] exp_vec();
        return {2'(m_lock), 1'(m_lock), 1'(m_pulse), 1'(m_zero),
                2'(m_lock), 1'(m_lock), 1'(m_pulse), 1'(m_zero),
                16'(m_err), 4'(m_err4)};
    endfunction

    function automatic void model_reset();
        hist.delete();
        m_lock = 0; m_matches = 0; m_misses = 0;
        m_pulse = 0; m_zero = 0; m_err = 0; m_err4 = 0;
    endfunction

    function automatic void model_step(input int v, input int b, input int c);
        int pred;
        m_pulse = 0;
        if (v != 0) begin
            if (m_lock == 0) begin
                if (hist.size() < 4) begin
                    hist.push_back(b);
                end else begin
                    pred = hist[0] ^ hist[1];
                    if ((hist[0] | hist[1] | hist[2] | hist[3]) == 0 && b == 0) begin
                        m_matches = 0;
                        m_zero = 1;
                    end else begin
                        m_zero = 0;
                        if (b == pred) begin
                            m_matches++;
                            if (m_matches == LOCK) begin
                                m_lock = 1; m_matches = 0; m_misses = 0;
                            end
                        end else begin
                            m_matches = 0;
                        end
                    end
                    void'(hist.pop_front());
                    hist.push_back(b);
                end
            end else begin
                pred = hist[0] ^ hist[1];
                void'(hist.pop_front());
                hist.push_back(pred);
                if (b != pred) begin
                    m_pulse = 1;
                    if (m_err < 65535) m_err++;
                    if (m_err4 < 15) m_err4++;
                    m_misses++;
                    if (m_misses == LOSS) begin
                        m_lock = 0; m_matches = 0; m_misses = 0;
                        hist.delete();
                    end
                end else begin
                    m_misses = 0;
                end
            end
        end
        if (c != 0) begin
            m_err = 0;
            m_err4 = 0;
        end
    endfunction

    task automatic drive_bit(input logic v, input logic b, input logic c);
        @(negedge clk);
        in_valid = v;
        in_bit   = b;
        clr      = c;
        model_step(int'(v), int'(b), int'(c));
        @(posedge clk);
        #1;
    endtask

    // Next generator bit (optionally inverted) on valid cycles; noise otherwise
    task automatic drive(input logic v, input logic inv, input logic c);
        logic b;
        if (v) begin
            b = pat[gen_idx] ^ inv;
            gen_idx = (gen_idx + 1) % 15;
        end else begin
            b = 1'($urandom);
        end
        drive_bit(v, b, c);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        in_valid = 1'b0; clr = 1'b0;
        rst = 1'b1;
        model_reset();
        gen_idx = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 1'b0; in_bit = 1'b0; clr = 1'b0; rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        gen_idx = 0;
        checks++;
        if (obs_vec() !== 30'd0) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs_vec(), 30'd0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_lock_clean();
        for (int i = 1; i <= 100; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL lock_clean bit %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (i == 11 || i == 12) begin
                checks++;
                if (locked !== (i == 12)) begin
                    errors++;
                    $display("FAIL lock_latency bit %0d: locked %b expected %b", i, locked, i == 12);
                end
            end
        end
        checks++;
        if (err_cnt !== 16'd0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL clean_100: err_cnt %0d locked %b expected 0/1", err_cnt, locked);
        end
    endtask

    task automatic test_single_error();
        drive(1'b1, 1'b1, 1'b0);
        checks++;
        if (err_pulse !== 1'b1 || err_cnt !== 16'd1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL single_error: pulse %b cnt %0d locked %b expected 1/1/1",
                     err_pulse, err_cnt, locked);
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec() || err_pulse !== 1'b0) begin
                errors++;
                $display("FAIL single_error_after %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_burst_loss();
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 1'b1, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec() || err_pulse !== 1'b1 || locked !== (k < 4)) begin
                errors++;
                $display("FAIL burst %0d: got %h expected %h", k, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (err_cnt !== 16'd5) begin
            errors++;
            $display("FAIL burst_count: err_cnt %0d expected 5", err_cnt);
        end
        for (int i = 1; i <= 12; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec() || locked !== (i == 12)) begin
                errors++;
                $display("FAIL relock bit %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_zero_stream();
        apply_reset();
        for (int i = 1; i <= 40; i++) begin
            drive_bit(1'b1, 1'b0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec() || locked !== 1'b0 || zero_det !== (i >= 5)) begin
                errors++;
                $display("FAIL zero_stream bit %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        drive_bit(1'b1, 1'b1, 1'b0);
        checks++;
        if (zero_det !== 1'b0 || err_cnt !== 16'd0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL zero_clear: zero_det %b err_cnt %0d expected 0/0", zero_det, err_cnt);
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 1'b0);
        for (int e = 0; e < 20; e++) begin
            for (int j = 0; j < 3; j++) begin
                drive(1'b1, 1'(j == 0), 1'b0);
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL saturate e%0d j%0d: got %h expected %h", e, j, obs_vec(), exp_vec());
                end
            end
        end
        checks++;
        if (err_cnt4 !== 4'd15 || err_cnt !== 16'd20 || locked4 !== 1'b1) begin
            errors++;
            $display("FAIL saturate_end: cnt4 %0d cnt %0d locked4 %b expected 15/20/1",
                     err_cnt4, err_cnt, locked4);
        end
        drive(1'b1, 1'b1, 1'b1);
        checks++;
        if (err_cnt4 !== 4'd0 || err_cnt !== 16'd0 || err_pulse4 !== 1'b1) begin
            errors++;
            $display("FAIL clr_priority: cnt4 %0d cnt %0d pulse %b expected 0/0/1",
                     err_cnt4, err_cnt, err_pulse4);
        end
    endtask

    task automatic test_random_valid();
        int nvalid = 0;
        int cyc = 0;
        logic v;
        apply_reset();
        while (nvalid < 20 && cyc < 300) begin
            v = 1'($urandom_range(0, 1));
            drive(v, 1'b0, 1'b0);
            cyc++;
            if (v) nvalid++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_valid cyc %0d: got %h expected %h", cyc, obs_vec(), exp_vec());
            end
            if (v && (nvalid == 11 || nvalid == 12)) begin
                checks++;
                if (locked !== (nvalid == 12) || err_cnt !== 16'd0) begin
                    errors++;
                    $display("FAIL random_valid_lock valid %0d: locked %b expected %b",
                             nvalid, locked, nvalid == 12);
                end
            end
        end
        checks++;
        if (nvalid < 20) begin
            errors++;
            $display("FAIL random_valid_budget: valid bits %0d expected 20", nvalid);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        gen_idx = 0;
        checks++;
        if (obs_vec() !== 30'd0) begin
            errors++;
            $display("FAIL reset_while_locked: got %h expected %h", obs_vec(), 30'd0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random_mix();
        int burst = 0;
        logic v, inv, c;
        for (int i = 0; i < 600; i++) begin
            if (burst == 0 && $urandom_range(0, 63) == 0) burst = $urandom_range(3, 5);
            v   = ($urandom_range(0, 3) != 0);
            inv = (burst > 0) || ($urandom_range(0, 15) == 0);
            c   = ($urandom_range(0, 47) == 0);
            if (v && burst > 0) burst--;
            drive(v, inv, c);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_mix cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        pat = 15'b001101011110001;
        gen_idx = 0;
        model_reset();
        test_reset();
        test_lock_clean();
        test_single_error();
        test_burst_loss();
        test_zero_stream();
        test_saturate();
        test_random_valid();
        test_random_mix();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iiitb_lfsr_checker.md
IIITB_LFSR_CHECKER -- requirements
Module: iiitb_lfsr_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 8: consecutive predicted-bit matches required to declare lock.
REQ-002 SHALL have parameter LOSS_THRESH, default 4: consecutive mismatches while locked that force loss of lock.
REQ-003 SHALL have parameter ERR_CNT_W, default 16: width of the error counter.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  in_bit is sampled on this clock edge.
REQ-007 SHALL have port in_bit  input  1  serial stream from the 4-bit LFSR generator, one bit per valid cycle.
REQ-008 SHALL have port clr  input  1  synchronous clear of err_cnt.
REQ-009 SHALL have port locked  output  1  checker is synchronised to the stream.
REQ-010 SHALL have port err_pulse  output  1  one-cycle flag for a mismatched bit while locked.
REQ-011 SHALL have port err_cnt  output  ERR_CNT_W  saturating count of mismatches while locked.
REQ-012 SHALL have port zero_det  output  1  all-zero history seen in HUNT (degenerate stream).
REQ-013 SHALL have port state  output  2  00 HUNT, 01 LOCKED.

Function
REQ-014 Sequence SHALL be b[n] = b[n-3] XOR b[n-4]; history register h[3:0], h[0] newest bit, predicted bit p = h[3] XOR h[2], update h <= {h[2:0], bit}.
REQ-015 With in_valid low, all state SHALL hold and err_pulse SHALL be 0 on the next cycle.
REQ-016 HUNT: the first 4 valid bits after entry SHALL only fill h (fill counter 0..4); no comparison.
REQ-017 HUNT, fill = 4: each valid bit SHALL be compared with p; h SHALL always shift in the received bit (self-synchronising).
REQ-018 HUNT match with h != 0: match_cnt SHALL increment; mismatch: match_cnt SHALL clear to 0.
REQ-019 HUNT, h = 0 and in_bit = 0: match_cnt SHALL clear, zero_det SHALL be 1 next cycle; zero_det SHALL clear on the next valid bit with h != 0 or in_bit = 1.
REQ-020 When the LOCK_CNT-th consecutive match is sampled, state SHALL be LOCKED and locked = 1 on the next cycle; miss_cnt SHALL clear.
REQ-021 LOCKED: h SHALL shift in p (free-running local LFSR), not in_bit, so one corrupt bit yields exactly one error.
REQ-022 LOCKED mismatch: err_pulse SHALL be 1 for exactly the next cycle, err_cnt SHALL increment and saturate at all-ones, and miss_cnt SHALL increment.
REQ-023 LOCKED match: miss_cnt SHALL clear to 0; err_pulse SHALL be 0.
REQ-024 When miss_cnt reaches LOSS_THRESH, the next state SHALL be HUNT, with locked = 0 and fill, match_cnt and miss_cnt cleared; err_cnt SHALL be retained.
REQ-025 The mismatch that reaches LOSS_THRESH SHALL still pulse err_pulse and count in err_cnt.
REQ-026 Mismatches in HUNT SHALL NOT affect err_pulse or err_cnt.
REQ-027 clr SHALL set err_cnt to 0 next cycle and SHALL take priority over a simultaneous increment; err_pulse SHALL still fire.
REQ-028 All outputs SHALL be registered; latency from sampled bit to any output effect is 1 cycle.

Reset
REQ-029 rst high SHALL immediately force state HUNT, locked 0, err_pulse 0, err_cnt 0, zero_det 0, and h, fill, match_cnt and miss_cnt to 0.
REQ-030 rst asserted mid-lock SHALL discard lock; reacquisition SHALL need 4 fill bits plus LOCK_CNT matches.

Verification
REQ-031 Generator seed 0001, continuous valid; period-15 stream 0,0,1,1,0,1,0,1,1,1,1,0,0,0,1 repeated -> locked = 1 the cycle after valid bit 12; err_cnt stays 0 over 100 bits.
REQ-032 After lock, invert one bit -> single err_pulse, err_cnt = 1, locked stays 1, following bits match.
REQ-033 After lock, invert 4 consecutive bits -> err_cnt = 4, locked = 0 after the 4th; relock 12 valid bits later on a clean stream.
REQ-034 Constant 0 stream (generator reset state) for 40 bits -> zero_det = 1, locked never asserts, err_cnt = 0.
REQ-035 ERR_CNT_W = 4, locked, one inverted bit every 3rd bit for 20 errors -> err_cnt saturates at 15, no loss of lock; clr with a simultaneous error -> err_cnt = 0, err_pulse = 1.
REQ-036 in_valid toggled randomly on a clean stream -> lock at the 12th valid bit, no errors; rst pulse while locked -> all outputs 0 immediately.
